// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
//   Shared types and constants for the fetch program-counter block.
//   - fetch_state_t  : request / wait-for-response / present-to-ID states
//   - redirect_src_t : which redirect source won arbitration this cycle
//   - INST_BYTES_DEF : default sequential PC increment
package pc_fetch_pkg;

  localparam int INST_BYTES_DEF = 4;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } fetch_state_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_TRAP,
    RD_MRET,
    RD_EX
  } redirect_src_t;

endpackage

// File: rtl/pc_redirect_sel.sv
// pc_redirect_sel
//   Combinational redirect arbiter. Picks the highest-priority redirect
//   (trap > mret > ex) and returns its target. Lower-priority requests in
//   the same cycle are ignored, not queued.
// Ports:
//   trap_valid, mtvec                      : trap redirect and target
//   mret_valid, mepc                       : mret redirect and target
//   ex_redirect_valid, ex_redirect_target  : EX branch/jump redirect and target
//   redirect_any                           : any redirect this cycle
//   target                                 : winning target (don't-care when none)
//   src                                    : winning source, RD_NONE when none
module pc_redirect_sel
  import pc_fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                trap_valid,
  input  logic [WIDTH-1:0]    mtvec,
  input  logic                mret_valid,
  input  logic [WIDTH-1:0]    mepc,
  input  logic                ex_redirect_valid,
  input  logic [WIDTH-1:0]    ex_redirect_target,
  output logic                redirect_any,
  output logic [WIDTH-1:0]    target,
  output redirect_src_t       src
);

  always_comb begin
    redirect_any = trap_valid | mret_valid | ex_redirect_valid;
    target       = ex_redirect_target;
    src          = RD_NONE;
    if (trap_valid) begin
      target = mtvec;
      src    = RD_TRAP;
    end else if (mret_valid) begin
      target = mepc;
      src    = RD_MRET;
    end else if (ex_redirect_valid) begin
      target = ex_redirect_target;
      src    = RD_EX;
    end
  end

endmodule

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen
//   Fetch program-counter block. Owns the architectural fetch PC, issues one
//   valid/ready request at a time to the IFU, buffers the returned
//   instruction until ID accepts it, and applies prioritised redirects
//   (trap > mret > EX). A fetch in flight when a redirect arrives is
//   squashed: its response is dropped when it returns.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   trap_valid / mtvec            : trap redirect
//   mret_valid / mepc             : mret redirect
//   ex_redirect_valid / _target   : EX taken branch / jal / jalr redirect
//   ifu_req_valid/_addr/_ready    : fetch request channel to the IFU
//   ifu_resp_valid / ifu_resp_inst: response for the outstanding request
//   out_valid/_pc/_inst/_ready    : instruction channel to ID
//   pc                            : next fetch address
//   redirect_misaligned           : one-cycle pulse, applied target[1:0] != 0
module pc_fetch_gen
  import pc_fetch_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter int               INST_BYTES   = INST_BYTES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] mtvec,
  input  logic             mret_valid,
  input  logic [WIDTH-1:0] mepc,
  input  logic             ex_redirect_valid,
  input  logic [WIDTH-1:0] ex_redirect_target,
  output logic             ifu_req_valid,
  output logic [WIDTH-1:0] ifu_req_addr,
  input  logic             ifu_req_ready,
  input  logic             ifu_resp_valid,
  input  logic [31:0]      ifu_resp_inst,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_pc,
  output logic [31:0]      out_inst,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pc,
  output logic             redirect_misaligned
);

  // Sequential successor; wraps silently at 2^WIDTH.
  function automatic logic [WIDTH-1:0] pc_step(input logic [WIDTH-1:0] cur);
    return cur + WIDTH'(INST_BYTES);
  endfunction

  function automatic logic low_bits_set(input logic [WIDTH-1:0] addr);
    return |addr[1:0];
  endfunction

  logic             redirect_any;
  logic [WIDTH-1:0] redir_target;
  redirect_src_t    redir_src;

  pc_redirect_sel #(
    .WIDTH (WIDTH)
  ) u_redirect_sel (
    .trap_valid         (trap_valid),
    .mtvec              (mtvec),
    .mret_valid         (mret_valid),
    .mepc               (mepc),
    .ex_redirect_valid  (ex_redirect_valid),
    .ex_redirect_target (ex_redirect_target),
    .redirect_any       (redirect_any),
    .target             (redir_target),
    .src                (redir_src)
  );

  fetch_state_t     state_q,    state_d;
  logic [WIDTH-1:0] pc_q,       pc_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [31:0]      inst_q,     inst_d;
  logic             drop_q,     drop_d;
  logic             misaligned_q, misaligned_d;

  // Next-state / next-value logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    inst_d       = inst_q;
    drop_d       = drop_q;
    misaligned_d = (redir_src != RD_NONE) && low_bits_set(redir_target);

    // A redirect always wins the PC, whatever the state.
    if (redirect_any) begin
      pc_d = redir_target;
    end

    unique case (state_q)
      S_REQ: begin
        if (ifu_req_ready) begin
          // The request goes out with the current pc even when a redirect
          // lands in the same cycle; that fetch is then marked for dropping.
          fetch_pc_d = pc_q;
          state_d    = S_WAIT;
          drop_d     = redirect_any;
          if (!redirect_any) begin
            pc_d = pc_step(pc_q);
          end
        end
      end

      S_WAIT: begin
        if (ifu_resp_valid) begin
          if (drop_q || redirect_any) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = ifu_resp_inst;
            state_d = S_OUT;
          end
        end else if (redirect_any) begin
          // Response still outstanding: remember to discard it.
          drop_d = 1'b1;
        end
      end

      S_OUT: begin
        // out_valid is killed combinationally by a redirect, so a redirect
        // and an ID handshake never coincide.
        if (redirect_any || out_ready) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_VECTOR;
      fetch_pc_q   <= RESET_VECTOR;
      inst_q       <= '0;
      drop_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      inst_q       <= inst_d;
      drop_q       <= drop_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Outputs; both valids are held low while reset is asserted.
  always_comb begin
    ifu_req_valid       = (state_q == S_REQ) && !rst;
    ifu_req_addr        = pc_q;
    out_valid           = (state_q == S_OUT) && !redirect_any && !rst;
    out_pc              = fetch_pc_q;
    out_inst            = inst_q;
    pc                  = pc_q;
    redirect_misaligned = misaligned_q;
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
module tb_pc_fetch_gen;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid, mret_valid, ex_redirect_valid;
  logic [31:0] mtvec, mepc, ex_redirect_target;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_inst;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic [31:0] pc;
  logic        redirect_misaligned;

  always #5 clk = ~clk;

  pc_fetch_gen #(
    .WIDTH        (32),
    .RESET_VECTOR (RV),
    .INST_BYTES   (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .trap_valid         (trap_valid),
    .mtvec              (mtvec),
    .mret_valid         (mret_valid),
    .mepc               (mepc),
    .ex_redirect_valid  (ex_redirect_valid),
    .ex_redirect_target (ex_redirect_target),
    .ifu_req_valid      (ifu_req_valid),
    .ifu_req_addr       (ifu_req_addr),
    .ifu_req_ready      (ifu_req_ready),
    .ifu_resp_valid     (ifu_resp_valid),
    .ifu_resp_inst      (ifu_resp_inst),
    .out_valid          (out_valid),
    .out_pc             (out_pc),
    .out_inst           (out_inst),
    .out_ready          (out_ready),
    .pc                 (pc),
    .redirect_misaligned(redirect_misaligned)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  // Scoreboard: instructions that must still reach ID, oldest first.
  exp_t        sb_q[$];
  logic [31:0] delivered[$];
  logic [31:0] accepted[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the fetch stream seen from outside.
  bit          known = 1'b0;
  logic [31:0] model_pc = RV;
  bit          exp_mis = 1'b0;
  bit          inflight = 1'b0;
  bit          killed = 1'b0;
  logic [31:0] inflight_addr = '0;
  int          resp_wait = 0;

  int p_ready = 100, p_out_ready = 100, min_delay = 0, max_delay = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, advance the model.
  task automatic step(input bit r, input bit tv, input bit mv, input bit ev,
                      input logic [31:0] mt, input logic [31:0] me, input logic [31:0] et);
    logic [31:0] tgt;
    bit          redir;
    bit          accept;
    exp_t        e;
    @(negedge clk);
    rst                = r;
    trap_valid         = tv;
    mret_valid         = mv;
    ex_redirect_valid  = ev;
    mtvec              = mt;
    mepc               = me;
    ex_redirect_target = et;
    ifu_req_ready      = ($urandom_range(99) < p_ready);
    out_ready          = ($urandom_range(99) < p_out_ready);
    ifu_resp_valid     = 1'b0;
    ifu_resp_inst      = $urandom;
    if (!r && inflight) begin
      if (resp_wait == 0) ifu_resp_valid = 1'b1;
      else resp_wait--;
    end
    #1;
    redir = tv | mv | ev;
    tgt   = tv ? mt : (mv ? me : et);
    if (r) begin
      check_bit("req_valid_in_rst", ifu_req_valid, 1'b0);
      check_bit("out_valid_in_rst", out_valid, 1'b0);
    end else if (known) begin
      check_bit("req_valid", ifu_req_valid, !inflight && sb_q.size() == 0);
      check_bit("out_valid", out_valid, sb_q.size() != 0 && !redir);
      check("pc", pc, model_pc);
      check_bit("misaligned", redirect_misaligned, exp_mis);
      if (ifu_req_valid === 1'b1) begin
        check_bit("one_outstanding", inflight, 1'b0);
        check("req_addr", ifu_req_addr, model_pc);
      end
    end
    accept = !r && (ifu_req_valid === 1'b1) && ifu_req_ready;
    if (r) begin
      known    = 1'b1;
      model_pc = RV;
      sb_q.delete();
      inflight = 1'b0;
      killed   = 1'b0;
      exp_mis  = 1'b0;
      return;
    end
    // Any redirect throws away everything not yet handed to ID.
    if (redir) sb_q.delete();
    if (ifu_resp_valid) begin
      inflight = 1'b0;
      if (!killed && !redir) begin
        e.pc   = inflight_addr;
        e.inst = ifu_resp_inst;
        sb_q.push_back(e);
      end
    end else if (inflight && redir) begin
      killed = 1'b1;
    end
    if (accept) begin
      accepted.push_back(model_pc);
      inflight      = 1'b1;
      inflight_addr = model_pc;
      killed        = redir;
      resp_wait     = $urandom_range(max_delay, min_delay);
    end
    exp_mis = redir && (tgt[1:0] != 2'b00);
    if (redir) model_pc = tgt;
    else if (accept) model_pc = model_pc + 32'd4;
  endtask

  task automatic quiet();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(9) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic rand_step(input int p_redir, input int p_rst);
    bit tv, mv, ev, r;
    tv = ($urandom_range(99) < p_redir);
    mv = ($urandom_range(99) < p_redir);
    ev = ($urandom_range(99) < p_redir);
    r  = ($urandom_range(999) < p_rst);
    step(r, tv, mv, ev, rand_target(), rand_target(), rand_target());
  endtask

  // Run quiet cycles until a fetch is outstanding with its response not due this cycle.
  task automatic wait_for_wait();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (inflight && resp_wait >= 1) ok = 1'b1;
      else quiet();
    end
    check_bit("wait_state_reached", ok, 1'b1);
  endtask

  // Monitor: compare whatever the DUT presents to ID against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_spurious: got out_pc %08h out_inst %08h, expected no output", out_pc, out_inst);
        end else begin
          check("out_pc", out_pc, sb_q[0].pc);
          check("out_inst", out_inst, sb_q[0].inst);
          if (out_ready) begin
            delivered.push_back(out_pc);
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int  n;
    bit  found;
    rst = 1'b1; trap_valid = 1'b0; mret_valid = 1'b0; ex_redirect_valid = 1'b0;
    mtvec = '0; mepc = '0; ex_redirect_target = '0;
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0; ifu_resp_inst = '0; out_ready = 1'b0;

    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Straight-line fetch, back-to-back responses, ID always ready.
    delivered.delete();
    repeat (12) quiet();
    check_bit("seq_count", delivered.size() >= 3, 1'b1);
    if (delivered.size() >= 3) begin
      check("seq0", delivered[0], RV);
      check("seq1", delivered[1], RV + 32'd4);
      check("seq2", delivered[2], RV + 32'd8);
    end

    // ID stall: output must hold, no new request.
    p_out_ready = 0;
    repeat (8) quiet();
    p_out_ready = 100;
    repeat (6) quiet();

    // EX redirect while waiting; response arrives the next cycle.
    min_delay = 1; max_delay = 1;
    wait_for_wait();
    n = accepted.size();
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 32'h8000_1000);
    min_delay = 0; max_delay = 0;
    repeat (8) quiet();
    check_bit("ex_redir_accepts", accepted.size() > n, 1'b1);
    if (accepted.size() > n) check("ex_redir_addr", accepted[n], 32'h8000_1000);

    // All three redirects together: trap wins.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0100, 32'h8000_0200, 32'h8000_0300);
    @(posedge clk); #1;
    check("simul_pc", pc, 32'h8000_0100);
    check_bit("simul_mis", redirect_misaligned, 1'b0);
    repeat (8) quiet();

    // PC wrap at the top of the address space.
    n = accepted.size();
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 32'hFFFF_FFFC);
    repeat (12) quiet();
    found = 1'b0;
    for (int i = n; i + 1 < accepted.size(); i++) begin
      if (!found && accepted[i] == 32'hFFFF_FFFC) begin
        found = 1'b1;
        check("wrap_next", accepted[i+1], 32'h0000_0000);
      end
    end
    check_bit("wrap_found", found, 1'b1);

    // Misaligned EX target: one-cycle pulse.
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 32'h8000_0002);
    @(posedge clk); #1;
    check_bit("mis_pulse", redirect_misaligned, 1'b1);
    quiet();
    @(posedge clk); #1;
    check_bit("mis_clear", redirect_misaligned, 1'b0);
    repeat (8) quiet();

    // Reset while a dropped fetch is still outstanding.
    min_delay = 3; max_delay = 3;
    wait_for_wait();
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 32'h8000_2000);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    min_delay = 0; max_delay = 0;
    n = accepted.size();
    repeat (6) quiet();
    check_bit("post_rst_accepts", accepted.size() > n, 1'b1);
    if (accepted.size() > n) check("post_rst_addr", accepted[n], RV);

    // Randomised traffic with occasional resets.
    p_ready = 70; p_out_ready = 70; min_delay = 0; max_delay = 3;
    repeat (3000) rand_step(6, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
